// File: rtl/dc_rm_pkg.sv
// Shared definitions for the DC-removal controller.
//   ST_WARMUP/ST_TRACK/ST_FREEZE : encodings reported on ctrl_state
//   dc_rm_state_e                : FSM state type built on those encodings
//   WARMUP_LEN_DEF               : default warm-up length (equals the averaging window)
package dc_rm_pkg;

  localparam logic [1:0] ST_WARMUP = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_FREEZE = 2'd2;

  typedef enum logic [1:0] {
    StWarmup = ST_WARMUP,
    StTrack  = ST_TRACK,
    StFreeze = ST_FREEZE
  } dc_rm_state_e;

  localparam int unsigned WARMUP_LEN_DEF = 128;

endpackage

// File: rtl/dc_rm_sat_cnt.sv
// Unsigned saturating counter: sticks at all-ones, never wraps.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear (wins over en)
//   en        : increment enable
//   cnt       : current count
module dc_rm_sat_cnt import dc_rm_pkg::*; #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dc_rm_ctrl.sv
// DC-removal controller: picks what feeds the DC subtractor. Zero during warm-up
// (after reset or a gain change), the live moving average while tracking, and a
// held value while a packet is in flight.
//   clk, rstn        : clock, asynchronous active-low reset
//   avg_i/avg_q      : moving-average estimate, qualified by avg_valid
//   gain_change      : AGC gain-update pulse
//   pkt_start/pkt_end: packet boundary pulses
//   freeze_timeout   : max freeze length in cycles, 0 disables
//   dc_i/dc_q        : DC value to the subtractor, dc_valid when trusted
//   ctrl_state       : 0 warm-up, 1 track, 2 freeze
//   timeout_flag     : one-cycle pulse when a freeze ends by timeout
// Build option: define DC_RM_CTRL_FREEZE_TIMEOUT_EN to build the freeze timeout;
// otherwise freeze_timeout is ignored and timeout_flag stays 0.
module dc_rm_ctrl import dc_rm_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned WARMUP_LEN = WARMUP_LEN_DEF,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic signed [DATA_WIDTH-1:0] avg_i,
  input  logic signed [DATA_WIDTH-1:0] avg_q,
  input  logic                         avg_valid,
  input  logic                         gain_change,
  input  logic                         pkt_start,
  input  logic                         pkt_end,
  input  logic        [CNT_WIDTH-1:0]  freeze_timeout,
  output logic signed [DATA_WIDTH-1:0] dc_i,
  output logic signed [DATA_WIDTH-1:0] dc_q,
  output logic                         dc_valid,
  output logic        [1:0]            ctrl_state,
  output logic                         timeout_flag
);

  localparam logic [CNT_WIDTH-1:0] WarmLast = CNT_WIDTH'(WARMUP_LEN - 1);

  dc_rm_state_e                 state_q, state_d;
  logic signed [DATA_WIDTH-1:0] dc_i_q, dc_i_d, dc_q_q, dc_q_d;
  logic                         valid_q, valid_d;
  logic                         gain_pend_q, gain_pend_d;
  logic                         tflag_q, tflag_d;

  logic [CNT_WIDTH-1:0] warm_cnt;
  logic                 warm_clr;
  logic                 timeout_hit;

  // Held at zero outside warm-up so every warm-up entry starts from 0.
  assign warm_clr = gain_change || (state_q != StWarmup);

  dc_rm_sat_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_warm_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (warm_clr),
    .en   (avg_valid),
    .cnt  (warm_cnt)
  );

`ifdef DC_RM_CTRL_FREEZE_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] to_cnt;
  logic                 to_clr;

  // Counts cycles spent in freeze; a pkt_start inside freeze restarts it.
  assign to_clr = (state_q != StFreeze) || pkt_start;

  dc_rm_sat_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_to_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (to_clr),
    .en   (1'b1),
    .cnt  (to_cnt)
  );

  // Fires one cycle early so the exit lands exactly freeze_timeout cycles after entry.
  assign timeout_hit = (state_q == StFreeze) && (freeze_timeout != '0) && !pkt_start &&
                       (to_cnt == freeze_timeout - CntOne);
`else
  logic unused_freeze_timeout;
  assign unused_freeze_timeout = ^freeze_timeout;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dc_i_d      = dc_i_q;
    dc_q_d      = dc_q_q;
    valid_d     = valid_q;
    gain_pend_d = gain_pend_q;
    tflag_d     = 1'b0;

    unique case (state_q)
      StWarmup: begin
        dc_i_d  = '0;
        dc_q_d  = '0;
        valid_d = 1'b0;
        if (!gain_change && avg_valid && (warm_cnt == WarmLast)) begin
          state_d = StTrack;
          dc_i_d  = avg_i;
          dc_q_d  = avg_q;
          valid_d = 1'b1;
        end
      end
      StTrack: begin
        if (gain_change) begin
          state_d = StWarmup;
          dc_i_d  = '0;
          dc_q_d  = '0;
          valid_d = 1'b0;
        end else if (pkt_start) begin
          state_d = StFreeze;
        end else if (avg_valid) begin
          dc_i_d = avg_i;
          dc_q_d = avg_q;
        end
      end
      StFreeze: begin
        if (gain_change) begin
          gain_pend_d = 1'b1;
        end
        if (pkt_end || timeout_hit) begin
          tflag_d     = !pkt_end;
          gain_pend_d = 1'b0;
          if (gain_pend_q || gain_change) begin
            state_d = StWarmup;
            dc_i_d  = '0;
            dc_q_d  = '0;
            valid_d = 1'b0;
          end else begin
            state_d = StTrack;
          end
        end
      end
      default: begin
        state_d = StWarmup;
        dc_i_d  = '0;
        dc_q_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StWarmup;
      dc_i_q      <= '0;
      dc_q_q      <= '0;
      valid_q     <= 1'b0;
      gain_pend_q <= 1'b0;
      tflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dc_i_q      <= dc_i_d;
      dc_q_q      <= dc_q_d;
      valid_q     <= valid_d;
      gain_pend_q <= gain_pend_d;
      tflag_q     <= tflag_d;
    end
  end

  assign dc_i         = dc_i_q;
  assign dc_q         = dc_q_q;
  assign dc_valid     = valid_q;
  assign ctrl_state   = state_q;
  assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_dc_rm_ctrl.sv
// Self-checking bench for dc_rm_ctrl: directed scenarios plus random traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_dc_rm_ctrl;

  localparam int DW = 16;
  localparam int WL = 128;
  localparam int CW = 16;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic signed [DW-1:0] avg_i, avg_q;
  logic                 avg_valid, gain_change, pkt_start, pkt_end;
  logic        [CW-1:0] freeze_timeout;
  logic signed [DW-1:0] dc_i, dc_q;
  logic                 dc_valid;
  logic        [1:0]    ctrl_state;
  logic                 timeout_flag;

  always #5 clk = ~clk;

  dc_rm_ctrl #(
    .DATA_WIDTH(DW),
    .WARMUP_LEN(WL),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .avg_i         (avg_i),
    .avg_q         (avg_q),
    .avg_valid     (avg_valid),
    .gain_change   (gain_change),
    .pkt_start     (pkt_start),
    .pkt_end       (pkt_end),
    .freeze_timeout(freeze_timeout),
    .dc_i          (dc_i),
    .dc_q          (dc_q),
    .dc_valid      (dc_valid),
    .ctrl_state    (ctrl_state),
    .timeout_flag  (timeout_flag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 warm-up, 1 track, 2 freeze; m_fcyc = cycles spent in freeze since entry/restart.
  int m_state, m_wcnt, m_fcyc, m_dci, m_dcq;
  bit m_pend, m_valid, m_tflag;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_wcnt = 0; m_fcyc = 0; m_dci = 0; m_dcq = 0;
    m_pend = 0; m_valid = 0; m_tflag = 0;
  endfunction

  function automatic void model_to_warmup();
    m_state = 0; m_wcnt = 0; m_dci = 0; m_dcq = 0; m_valid = 0;
  endfunction

  function automatic void model_step(bit gc, bit av, bit ps, bit pe, int ai, int aq, int to);
    bit leave;
    m_tflag = 0;
    case (m_state)
      0: begin
        if (gc) m_wcnt = 0;
        else if (av) begin
          m_wcnt++;
          if (m_wcnt == WL) begin
            m_state = 1; m_dci = ai; m_dcq = aq; m_valid = 1; m_wcnt = 0;
          end
        end
      end
      1: begin
        if (gc) model_to_warmup();
        else if (ps) begin m_state = 2; m_fcyc = 0; end
        else if (av) begin m_dci = ai; m_dcq = aq; end
      end
      default: begin
        if (gc) m_pend = 1;
        m_fcyc++;
        leave = pe;
        if (!pe) begin
          if (ps) m_fcyc = 0;
`ifdef DC_RM_CTRL_FREEZE_TIMEOUT_EN
          else if (to != 0 && m_fcyc == to) begin leave = 1; m_tflag = 1; end
`endif
        end
        if (leave) begin
          if (m_pend) model_to_warmup();
          else m_state = 1;
          m_pend = 0;
        end
      end
    endcase
  endfunction

  task automatic compare_all();
    check("ctrl_state", ctrl_state, m_state);
    check("dc_i", dc_i, m_dci);
    check("dc_q", dc_q, m_dcq);
    check("dc_valid", dc_valid, m_valid);
    check("timeout_flag", timeout_flag, m_tflag);
  endtask

  // Call just after a clock edge (or at a negedge); drives inputs for the next edge.
  task automatic step(input bit gc, input bit av, input bit ps, input bit pe,
                      input int ai, input int aq);
    gain_change = gc; avg_valid = av; pkt_start = ps; pkt_end = pe;
    avg_i = DW'(ai); avg_q = DW'(aq);
    @(posedge clk);
    model_step(gc, av, ps, pe, ai, aq, int'(freeze_timeout));
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic warm_up(input int ai, input int aq);
    for (int k = 0; k < WL; k++) step(0, 1, 0, 0, ai, aq);
  endtask

  initial begin
    int cnt;
    rstn = 0; avg_i = '0; avg_q = '0; avg_valid = 0; gain_change = 0;
    pkt_start = 0; pkt_end = 0; freeze_timeout = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rstn = 1;

    // Warm-up: 127 valids keep warm-up, the 128th enters track.
    for (int k = 0; k < WL - 1; k++) step(0, 1, 0, 0, 100, -50);
    check("warm_127_state", ctrl_state, 0);
    check("warm_127_valid", dc_valid, 0);
    step(0, 1, 0, 0, 100, -50);
    check("warm_128_state", ctrl_state, 1);
    check("warm_128_dci", dc_i, 100);
    check("warm_128_valid", dc_valid, 1);

    // Freeze holds across many valids; same-cycle sample is not loaded.
    step(0, 1, 1, 0, 200, 7);
    check("frz_entry_dci", dc_i, 100);
    for (int k = 0; k < 500; k++) step(0, 1, 0, 0, $urandom_range(0, 2000), 3);
    check("frz_hold_dci", dc_i, 100);
    step(0, 0, 0, 1, 0, 0);
    check("frz_exit_state", ctrl_state, 1);
    step(0, 1, 0, 0, 300, -300);
    check("track_reload_dci", dc_i, 300);

    // Gain change during freeze is deferred until pkt_end.
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("frz_gain_stays", ctrl_state, 2);
    step(0, 0, 0, 1, 0, 0);
    check("pend_exit_state", ctrl_state, 0);
    check("pend_exit_dci", dc_i, 0);
    for (int k = 0; k < WL - 1; k++) step(0, 1, 0, 0, 11, 22);
    check("rewarm_127_state", ctrl_state, 0);
    step(0, 1, 0, 0, 11, 22);
    check("rewarm_128_state", ctrl_state, 1);

`ifdef DC_RM_CTRL_FREEZE_TIMEOUT_EN
    freeze_timeout = CW'(50);
    step(0, 0, 1, 0, 0, 0);
    cnt = 0;
    while (cnt < 200 && timeout_flag !== 1'b1) begin
      step(0, 0, 0, 0, 0, 0);
      cnt++;
    end
    check("timeout_cycles", cnt, 50);
    check("timeout_state", ctrl_state, 1);
    freeze_timeout = '0;
    step(0, 0, 1, 0, 0, 0);
    idle(200);
    check("no_timeout_state", ctrl_state, 2);
    step(0, 0, 0, 1, 0, 0);
`else
    freeze_timeout = CW'(5);
    step(0, 0, 1, 0, 0, 0);
    idle(100);
    check("no_timeout_state", ctrl_state, 2);
    check("no_timeout_flag", timeout_flag, 0);
    step(0, 0, 0, 1, 0, 0);
    freeze_timeout = '0;
`endif

    // Gain change beats pkt_start in track.
    step(1, 1, 1, 0, 5, 5);
    check("gc_ps_state", ctrl_state, 0);

    // Asynchronous reset mid-freeze.
    warm_up(-77, 99);
    step(0, 0, 1, 0, 0, 0);
    check("pre_rst_state", ctrl_state, 2);
    #3;
    rstn = 0;
    #1;
    model_reset();
    check("arst_state", ctrl_state, 0);
    check("arst_dci", dc_i, 0);
    check("arst_dcq", dc_q, 0);
    check("arst_valid", dc_valid, 0);
    check("arst_tflag", timeout_flag, 0);
    @(negedge clk);
    rstn = 1;

    // Random traffic.
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 3))
          0: freeze_timeout = '0;
          1: freeze_timeout = CW'(7);
          2: freeze_timeout = CW'(20);
          default: freeze_timeout = CW'(50);
        endcase
      end
      step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
